// File: rtl/wb_write_queue_pkg.sv
// Shared widths, defaults and types for the regfile write queue.
package wb_write_queue_pkg;

  // Regfile geometry shared with the decode-stage register file.
  localparam int unsigned REG_ADDR  = 5;
  localparam int unsigned REG_SIZE  = 32;
  localparam int unsigned REG_N     = 32;
  // Default number of port-B queue entries.
  localparam int unsigned WBQ_DEPTH = 4;

  // Which source drives the output register this cycle.
  typedef enum logic [1:0] {
    SrcIdle,
    SrcPortA,
    SrcQueue,
    SrcPortB
  } out_src_e;

  // r0 is hardwired to zero, so writes to it are dropped.
  function automatic logic is_r0(input logic [REG_ADDR-1:0] r);
    return r == '0;
  endfunction

endpackage

// File: rtl/wbq_fifo.sv
// Port-B holding queue: storage, per-entry valid bits, pointers, occupancy
// and invalidate-by-address. Invalidated entries keep their slot.
module wbq_fifo
  import wb_write_queue_pkg::*;
#(
  parameter int unsigned DEPTH = WBQ_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic [REG_ADDR-1:0]                 push_reg,
  input  logic [REG_SIZE-1:0]                 push_data,
  input  logic                                pop,
  input  logic                                inv_en,
  input  logic [REG_ADDR-1:0]                 inv_reg,
  output logic [DEPTH-1:0]                    ent_vld,
  output logic [DEPTH-1:0][REG_ADDR-1:0]      ent_reg,
  output logic [DEPTH-1:0][REG_SIZE-1:0]      ent_data,
  output logic [$clog2(DEPTH)-1:0]            rd_ptr,
  output logic [$clog2(DEPTH):0]              count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic          push_vld;

  // An entry pushed alongside a same-register port-A write is already stale.
  assign push_vld = !(inv_en && (inv_reg == push_reg));

  // Control state: valid bits, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (inv_en && ent_vld[i] && (ent_reg[i] == inv_reg)) ent_vld[i] <= 1'b0;
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (push) begin
        ent_vld[wr_ptr] <= push_vld;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg[wr_ptr]  <= push_reg;
      ent_data[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Merges the in-order writeback path (A) and a long-latency unit (B) onto
// the single regfile write port, with pending-write lookup for forwarding.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int unsigned DEPTH = WBQ_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_valid,
  input  logic [REG_ADDR-1:0]       a_reg,
  input  logic [REG_SIZE-1:0]       a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [REG_ADDR-1:0]       b_reg,
  input  logic [REG_SIZE-1:0]       b_data,
  output logic                      regwrite,
  output logic [REG_ADDR-1:0]       wreg,
  output logic [REG_SIZE-1:0]       wdata,
  input  logic [REG_ADDR-1:0]       rreg1,
  input  logic [REG_ADDR-1:0]       rreg2,
  output logic                      pend_hit1,
  output logic                      pend_hit2,
  output logic [REG_SIZE-1:0]       pend_data1,
  output logic [REG_SIZE-1:0]       pend_data2,
  output logic [$clog2(DEPTH):0]    q_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0]               ent_vld;
  logic [DEPTH-1:0][REG_ADDR-1:0] ent_reg;
  logic [DEPTH-1:0][REG_SIZE-1:0] ent_data;
  logic [PW-1:0]                  rd_ptr;

  out_src_e            src;
  logic                b_xfer, push, pop, inv_en;
  logic                regwrite_d;
  logic [REG_ADDR-1:0] wreg_d;
  logic [REG_SIZE-1:0] wdata_d;

  // Ready depends only on registered occupancy, never on this cycle's pops.
  assign b_ready = (q_count != ($clog2(DEPTH)+1)'(DEPTH));
  assign b_xfer  = b_valid && b_ready;
  assign inv_en  = a_valid && !is_r0(a_reg);

  // Output source priority: A, then queue head, then direct B.
  always_comb begin
    src = SrcIdle;
    if (a_valid)              src = SrcPortA;
    else if (q_count != '0)   src = SrcQueue;
    else if (b_xfer)          src = SrcPortB;
  end

  assign pop  = (src == SrcQueue);
  assign push = b_xfer && (src != SrcPortB) && !is_r0(b_reg);

  // Next value of the registered write port; zeroed when nothing is written.
  always_comb begin
    regwrite_d = 1'b0;
    wreg_d     = '0;
    wdata_d    = '0;
    unique case (src)
      SrcPortA: if (!is_r0(a_reg)) begin
        regwrite_d = 1'b1;
        wreg_d     = a_reg;
        wdata_d    = a_data;
      end
      SrcQueue: if (ent_vld[rd_ptr]) begin
        regwrite_d = 1'b1;
        wreg_d     = ent_reg[rd_ptr];
        wdata_d    = ent_data[rd_ptr];
      end
      SrcPortB: if (!is_r0(b_reg)) begin
        regwrite_d = 1'b1;
        wreg_d     = b_reg;
        wdata_d    = b_data;
      end
      default: ;
    endcase
  end

  // Registered regfile write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite <= 1'b0;
      wreg     <= '0;
      wdata    <= '0;
    end else begin
      regwrite <= regwrite_d;
      wreg     <= wreg_d;
      wdata    <= wdata_d;
    end
  end

  wbq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_reg  (b_reg),
    .push_data (b_data),
    .pop       (pop),
    .inv_en    (inv_en),
    .inv_reg   (a_reg),
    .ent_vld   (ent_vld),
    .ent_reg   (ent_reg),
    .ent_data  (ent_data),
    .rd_ptr    (rd_ptr),
    .count     (q_count)
  );

  logic [1:0][REG_ADDR-1:0] rreg_sel;
  logic [1:0]               hit;
  logic [1:0][REG_SIZE-1:0] hit_data;

  assign rreg_sel = {rreg2, rreg1};

  // Lookup: output stage first, then queue walked oldest to youngest so the
  // youngest valid match overrides.
  always_comb begin
    hit      = '0;
    hit_data = '0;
    for (int k = 0; k < 2; k++) begin
      if (!is_r0(rreg_sel[k])) begin
        if (regwrite && (wreg == rreg_sel[k])) begin
          hit[k]      = 1'b1;
          hit_data[k] = wdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_vld[rd_ptr + PW'(i)] && (ent_reg[rd_ptr + PW'(i)] == rreg_sel[k])) begin
            hit[k]      = 1'b1;
            hit_data[k] = ent_data[rd_ptr + PW'(i)];
          end
        end
      end
    end
  end

  assign pend_hit1  = hit[0];
  assign pend_hit2  = hit[1];
  assign pend_data1 = hit_data[0];
  assign pend_data2 = hit_data[1];

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: vector table plus multi-cycle sequences.
module tb_wb_write_queue;
  import wb_write_queue_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                a_valid, b_valid, b_ready;
  logic [REG_ADDR-1:0] a_reg, b_reg, wreg, rreg1, rreg2;
  logic [REG_SIZE-1:0] a_data, b_data, wdata, pend_data1, pend_data2;
  logic                regwrite, pend_hit1, pend_hit2;
  logic [2:0]          q_count;

  int nvec  = 0;
  int nfail = 0;

  wb_write_queue #(
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_reg      (a_reg),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_reg      (b_reg),
    .b_data     (b_data),
    .regwrite   (regwrite),
    .wreg       (wreg),
    .wdata      (wdata),
    .rreg1      (rreg1),
    .rreg2      (rreg2),
    .pend_hit1  (pend_hit1),
    .pend_hit2  (pend_hit2),
    .pend_data1 (pend_data1),
    .pend_data2 (pend_data2),
    .q_count    (q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_we;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic        e_rdy;
    logic [2:0]  e_cnt;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t vecs[$];

  // Write log captured once per cycle while enabled.
  logic        mon_en = 1'b0;
  logic [4:0]  log_reg[$];
  logic [31:0] log_data[$];

  always @(negedge clk) begin
    if (mon_en && regwrite) begin
      log_reg.push_back(wreg);
      log_data.push_back(wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    rreg1 = '0; rreg2 = '0;
  endtask

  initial begin
    int bi;
    int xfers;
    logic [4:0]  exp_reg[$];
    logic [31:0] exp_data[$];

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    rreg1 = 5'd5;
    #1;
    chk("rst_regwrite", 32'(regwrite), 32'd0);
    chk("rst_wreg", 32'(wreg), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_qcount", 32'(q_count), 32'd0);
    chk("rst_bready", 32'(b_ready), 32'd1);
    chk("rst_hit1", 32'(pend_hit1), 32'd0);
    chk("rst_data1", pend_data1, 32'd0);

    //             av ar  ad      bv br  bd    r1 r2  we wr  wdata    rdy cnt h1 d1       h2 d2
    vecs.push_back('{1, 5, 32'h1234, 0, 0, 0,    5, 0,  0, 0, 0,       1, 0,  0, 0,       0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,    5, 0,  1, 5, 32'h1234,1, 0,  1, 32'h1234,0, 0});
    vecs.push_back('{1, 3, 32'hA,    1, 4, 32'hB,0, 0,  0, 0, 0,       1, 0,  0, 0,       0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,    4, 3,  1, 3, 32'hA,   1, 1,  1, 32'hB,   1, 32'hA});
    vecs.push_back('{0, 0, 0,        0, 0, 0,    4, 0,  1, 4, 32'hB,   1, 0,  1, 32'hB,   0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,    4, 0,  0, 0, 0,       1, 0,  0, 0,       0, 0});
    // Stale queued r7 overwritten by a younger port-A write.
    vecs.push_back('{1, 9, 32'h99,   1, 7, 32'h1,0, 0,  0, 0, 0,       1, 0,  0, 0,       0, 0});
    vecs.push_back('{1, 7, 32'h2,    0, 0, 0,    7, 0,  1, 9, 32'h99,  1, 1,  1, 32'h1,   0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,    7, 0,  1, 7, 32'h2,   1, 1,  1, 32'h2,   0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,    7, 0,  0, 0, 0,       1, 0,  0, 0,       0, 0});
    // r0 writes from both ports.
    vecs.push_back('{1, 0, 32'h5,    1, 0, 32'h6,0, 0,  0, 0, 0,       1, 0,  0, 0,       0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,    0, 0,  0, 0, 0,       1, 0,  0, 0,       0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,    0, 0,  0, 0, 0,       1, 0,  0, 0,       0, 0});
    // Back-to-back direct port-B writes.
    vecs.push_back('{0, 0, 0,        1, 1, 32'h11,1, 0, 0, 0, 0,       1, 0,  0, 0,       0, 0});
    vecs.push_back('{0, 0, 0,        1, 2, 32'h22,1, 2, 1, 1, 32'h11,  1, 0,  1, 32'h11,  0, 0});
    vecs.push_back('{0, 0, 0,        0, 0, 0,    1, 2,  1, 2, 32'h22,  1, 0,  0, 0,       1, 32'h22});
    vecs.push_back('{0, 0, 0,        0, 0, 0,    2, 0,  0, 0, 0,       1, 0,  0, 0,       0, 0});

    foreach (vecs[i]) begin
      @(negedge clk);
      a_valid = vecs[i].av; a_reg = vecs[i].ar; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_reg = vecs[i].br; b_data = vecs[i].bd;
      rreg1   = vecs[i].r1; rreg2 = vecs[i].r2;
      #1;
      chk($sformatf("v%0d_regwrite", i), 32'(regwrite), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_wreg", i), 32'(wreg), 32'(vecs[i].e_wreg));
      chk($sformatf("v%0d_wdata", i), wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_bready", i), 32'(b_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_qcount", i), 32'(q_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_hit1", i), 32'(pend_hit1), 32'(vecs[i].e_h1));
      chk($sformatf("v%0d_data1", i), pend_data1, vecs[i].e_d1);
      chk($sformatf("v%0d_hit2", i), 32'(pend_hit2), 32'(vecs[i].e_h2));
      chk($sformatf("v%0d_data2", i), pend_data2, vecs[i].e_d2);
    end

    // Sustained A for 8 cycles while B offers 6 writes: queue fills at 4.
    bi = 0;
    xfers = 0;
    mon_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      idle_inputs();
      a_valid = 1'b1; a_reg = 5'(20 + c); a_data = 32'h100 + 32'(c);
      b_valid = (bi < 6); b_reg = 5'(10 + bi); b_data = 32'hB0 + 32'(bi);
      #1;
      if (b_valid && b_ready) begin
        bi++;
        xfers++;
      end
    end
    chk("fill_xfers", 32'(xfers), 32'd4);
    chk("fill_bready", 32'(b_ready), 32'd0);
    chk("fill_qcount", 32'(q_count), 32'd4);
    // First drain cycle: queue still full, so no transfer yet.
    @(negedge clk);
    idle_inputs();
    b_valid = (bi < 6); b_reg = 5'(10 + bi); b_data = 32'hB0 + 32'(bi);
    #1;
    chk("drain_full_bready", 32'(b_ready), 32'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      idle_inputs();
      b_valid = (bi < 6); b_reg = 5'(10 + bi); b_data = 32'hB0 + 32'(bi);
      #1;
      if (b_valid && b_ready) bi++;
    end
    mon_en = 1'b0;
    chk("drain_all_sent", 32'(bi), 32'd6);
    chk("drain_qcount", 32'(q_count), 32'd0);
    for (int c = 0; c < 8; c++) begin
      exp_reg.push_back(5'(20 + c));
      exp_data.push_back(32'h100 + 32'(c));
    end
    for (int c = 0; c < 6; c++) begin
      exp_reg.push_back(5'(10 + c));
      exp_data.push_back(32'hB0 + 32'(c));
    end
    chk("order_len", 32'(log_reg.size()), 32'(exp_reg.size()));
    for (int i = 0; i < exp_reg.size() && i < log_reg.size(); i++) begin
      chk($sformatf("order%0d_reg", i), 32'(log_reg[i]), 32'(exp_reg[i]));
      chk($sformatf("order%0d_data", i), log_data[i], exp_data[i]);
    end

    // Reset with three entries queued behind a busy port A.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      a_valid = 1'b1; a_reg = 5'd1; a_data = 32'(c);
      b_valid = 1'b1; b_reg = 5'(2 + c); b_data = 32'hC0 + 32'(c);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("prerst_qcount", 32'(q_count), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    rreg1 = 5'd2;
    #1;
    chk("postrst_qcount", 32'(q_count), 32'd0);
    chk("postrst_bready", 32'(b_ready), 32'd1);
    chk("postrst_regwrite", 32'(regwrite), 32'd0);
    chk("postrst_hit1", 32'(pend_hit1), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("postrst%0d_regwrite", c), 32'(regwrite), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
